// File: rtl/timebase_shift_sequencer.sv
// Purpose : control stage ahead of the timebase shifter core; latches a double-buffered
//           phase shift, has the shifter count it down, then enables the carrier counter.
// Latency : start sampled at edge k -> RUN / counter_enable from edge k+1+S (S = shadow at k).
// Flow    : no backpressure; start is ignored while busy, stop returns to IDLE next edge.
//
// Ports:
//   clockIn, reset (async, active-low)
//   start, stop          one-cycle control pulses from the PWM generator registers
//   shift_value,
//   shadow_update        write port of the shadow phase-shift register
//   period_tick          carrier counter wrap pulse (used only with synchronous stop)
//   shifter_count        shifter core count_out
//   shifter_load/enable/count_in   shifter core controls
//   counter_enable       carrier counter enable (high in RUN)
//   busy, done           status: not idle / first cycle in RUN
//
// Build option: define TIMEBASE_SHIFT_SYNC_STOP_EN to defer a stop issued in RUN
// until the next period_tick, so the carrier always finishes its current period.
module timebase_shift_sequencer #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clockIn,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [COUNTER_WIDTH-1:0] shift_value,
  input  logic                     shadow_update,
  input  logic                     period_tick,
  input  logic [COUNTER_WIDTH-1:0] shifter_count,
  output logic                     shifter_load,
  output logic                     shifter_enable,
  output logic [COUNTER_WIDTH-1:0] shifter_count_in,
  output logic                     counter_enable,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DELAY = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] shadow_q, shadow_d;
  logic [COUNTER_WIDTH-1:0] active_q, active_d;
  logic                     done_q, done_d;
`ifdef TIMEBASE_SHIFT_SYNC_STOP_EN
  logic                     stop_pending_q, stop_pending_d;
`else
  logic                     unused_period_tick;
  assign unused_period_tick = period_tick;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_update ? shift_value : shadow_q;
    active_d = active_q;
`ifdef TIMEBASE_SHIFT_SYNC_STOP_EN
    stop_pending_d = stop_pending_q;
`endif
    case (state_q)
      IDLE: begin
        // stop wins over a simultaneous start; active takes the pre-update shadow
        if (start && !stop) begin
          state_d  = LOAD;
          active_d = shadow_q;
        end
      end
      LOAD: begin
        if (stop)                 state_d = IDLE;
        else if (active_q == '0)  state_d = RUN;
        else                      state_d = DELAY;
      end
      DELAY: begin
        // Count 1 leaves on the edge that decrements it to 0; count 0 (shifter
        // cleared externally) leaves without enabling, so it can never wrap.
        if (stop)                                      state_d = IDLE;
        else if (shifter_count <= COUNTER_WIDTH'(1))   state_d = RUN;
      end
      RUN: begin
`ifdef TIMEBASE_SHIFT_SYNC_STOP_EN
        if (stop || stop_pending_q) begin
          if (period_tick) begin
            state_d        = IDLE;
            stop_pending_d = 1'b0;
          end else begin
            stop_pending_d = 1'b1;
          end
        end
`else
        if (stop) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == RUN) && (state_q != RUN);
  end

  always_ff @(posedge clockIn or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

`ifdef TIMEBASE_SHIFT_SYNC_STOP_EN
  always_ff @(posedge clockIn or negedge reset) begin
    if (!reset) stop_pending_q <= 1'b0;
    else        stop_pending_q <= stop_pending_d;
  end
`endif

  // Outputs decode registered state; shifter_enable also looks at the live
  // count so the shifter is never told to decrement from zero.
  assign shifter_load     = (state_q == LOAD);
  assign shifter_enable   = (state_q == DELAY) && (shifter_count != '0);
  assign shifter_count_in = active_q;
  assign counter_enable   = (state_q == RUN);
  assign busy             = (state_q != IDLE);
  assign done             = done_q;

endmodule
